// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN input-window generator slice.
//   WI      : bits per activation / lane
//   N       : lanes in the window bus feeding conv_kern
//   MAX_W   : maximum frame width, also the line-buffer depth
//   W_SIZE  : width of the width/height/row/col counters
//   state_e : window-generator FSM states
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int WI     = 8;
    localparam int N      = 16;
    localparam int MAX_W  = 4096;
    localparam int W_SIZE = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/cnn_win_gen_if.sv
// -----------------------------------------------------------------------------
// cnn_win_gen_if
// Pixel-stream input and window output bundle of cnn_win_gen.
//   i_pix / i_pix_vld          : raster activation stream (no backpressure)
//   o_din                      : N*WI window bus, lane k = 3*dy+dx
//   o_vld                      : o_din valid
//   o_row / o_col              : centre coordinate of o_din
//   o_frame_done               : pulse with the last window of a frame
// Modports: master = stream source / window sink, slave = cnn_win_gen.
// -----------------------------------------------------------------------------
interface cnn_win_gen_if
    import cnn_pkg::*;
#(
    parameter int IF_WI     = cnn_pkg::WI,
    parameter int IF_N      = cnn_pkg::N,
    parameter int IF_W_SIZE = cnn_pkg::W_SIZE
);

    logic [IF_WI-1:0]      i_pix;
    logic                  i_pix_vld;
    logic [IF_N*IF_WI-1:0] o_din;
    logic                  o_vld;
    logic [IF_W_SIZE-1:0]  o_row;
    logic [IF_W_SIZE-1:0]  o_col;
    logic                  o_frame_done;

    modport master (
        output i_pix, i_pix_vld,
        input  o_din, o_vld, o_row, o_col, o_frame_done
    );

    modport slave (
        input  i_pix, i_pix_vld,
        output o_din, o_vld, o_row, o_col, o_frame_done
    );

endinterface

// File: rtl/cnn_line_buf.sv
// -----------------------------------------------------------------------------
// cnn_line_buf
// One line of activations: DEPTH x WIDTH storage, one write port and one read
// port sharing the same column address. The read is combinational from the
// current contents, so a read and a write to the same column in one cycle
// returns the old value (read-before-write).
//   clk   : clock
//   we    : write enable
//   addr  : column index (shared by read and write)
//   wdata : value written at addr on the clock edge
//   rdata : value currently stored at addr
// -----------------------------------------------------------------------------
module cnn_line_buf #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/cnn_win_gen.sv
// -----------------------------------------------------------------------------
// cnn_win_gen
// Input-window generator in front of the 16-lane conv_kern array. Consumes a
// raster stream of activations and emits either a zero-padded 3x3 window or a
// single pixel (1x1) per output cycle.
//   HCLK, HRESETn   : clock, asynchronous active-low reset
//   i_start         : pulse; latches i_width/i_height/i_is_conv3x3 and starts
//   i_width/height  : frame size W,H (both must be non-zero)
//   i_is_conv3x3    : 1 = 3x3 window, 0 = 1x1 pass-through
//   o_busy          : frame in progress
//   s_if            : pixel stream in, window bus out (see cnn_win_gen_if)
// Window lane k = 3*dy+dx holds pixel (row-1+dy, col-1+dx); lanes 9..N-1 are 0.
// -----------------------------------------------------------------------------
module cnn_win_gen
    import cnn_pkg::*;
#(
    parameter int WI     = cnn_pkg::WI,
    parameter int N      = cnn_pkg::N,
    parameter int MAX_W  = cnn_pkg::MAX_W,
    parameter int W_SIZE = cnn_pkg::W_SIZE
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_start,
    input  logic [W_SIZE-1:0] i_width,
    input  logic [W_SIZE-1:0] i_height,
    input  logic              i_is_conv3x3,
    output logic              o_busy,
    cnn_win_gen_if.slave      s_if
);

    localparam int                AW  = $clog2(MAX_W);
    localparam logic [W_SIZE-1:0] ONE = W_SIZE'(1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic [W_SIZE-1:0] width_q, width_d, height_q, height_d;
    logic              is3_q, is3_d;
    // Position of the next incoming sample (input or flush).
    logic [W_SIZE-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
    // Centre of the next window to be emitted.
    logic [W_SIZE-1:0] c_row_q, c_row_d, c_col_q, c_col_d;
    // Saturating count of accepted samples up to the W+1 lag.
    logic [W_SIZE:0]   lag_q, lag_d;
    logic              vld_q, vld_d, done_q, done_d;
    logic [W_SIZE-1:0] row_q, row_d, col_q, col_d;
    logic [N*WI-1:0]   din_q, din_d;
    logic [WI-1:0]     win_q [3][3];
    logic [WI-1:0]     win_d [3][3];

    logic [WI-1:0]     lb0_rd, lb1_rd, samp;
    logic              accept, start_ok, last_in, end_c, emit;

    // Zero every lane whose source pixel lies outside the frame.
    function automatic logic [N*WI-1:0] pad_window(
        input logic [WI-1:0] w [3][3],
        input logic          top,
        input logic          bot,
        input logic          lft,
        input logic          rgt
    );
        logic [N*WI-1:0] res;
        res = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                if (!((dy == 0 && top) || (dy == 2 && bot) ||
                      (dx == 0 && lft) || (dx == 2 && rgt))) begin
                    res[(3*dy+dx)*WI +: WI] = w[dy][dx];
                end
            end
        end
        return res;
    endfunction

    // lb0 holds the row above the incoming sample, lb1 the row above that.
    cnn_line_buf #(.DEPTH(MAX_W), .WIDTH(WI)) u_lb0 (
        .clk   (HCLK),
        .we    (accept && is3_q),
        .addr  (AW'(in_col_q)),
        .wdata (samp),
        .rdata (lb0_rd)
    );

    cnn_line_buf #(.DEPTH(MAX_W), .WIDTH(WI)) u_lb1 (
        .clk   (HCLK),
        .we    (accept && is3_q),
        .addr  (AW'(in_col_q)),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        accept   = (state_q == ST_RUN && s_if.i_pix_vld) || (state_q == ST_FLUSH);
        samp     = (state_q == ST_RUN) ? s_if.i_pix : '0;
        last_in  = (in_row_q == height_q - ONE) && (in_col_q == width_q - ONE);
        end_c    = (c_row_q == height_q - ONE) && (c_col_q == width_q - ONE);
        emit     = accept && (!is3_q || lag_q == ({1'b0, width_q} + (W_SIZE+1)'(1)));
        start_ok = i_start && (state_q == ST_IDLE) && (i_width != '0) &&
                   (int'(i_width) <= MAX_W) && (i_height != '0);

        state_d  = state_q;
        busy_d   = busy_q;
        width_d  = width_q;
        height_d = height_q;
        is3_d    = is3_q;
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        c_row_d  = c_row_q;
        c_col_d  = c_col_q;
        lag_d    = lag_q;
        vld_d    = 1'b0;
        done_d   = 1'b0;
        row_d    = row_q;
        col_d    = col_q;
        din_d    = din_q;
        win_d    = win_q;

        // Window shifts one column per accepted sample; the new right column
        // comes from the two line buffers and the sample itself.
        if (accept) begin
            for (int dy = 0; dy < 3; dy++) begin
                win_d[dy][0] = win_q[dy][1];
                win_d[dy][1] = win_q[dy][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = samp;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                    width_d  = i_width;
                    height_d = i_height;
                    is3_d    = i_is_conv3x3;
                    in_row_d = '0;
                    in_col_d = '0;
                    c_row_d  = '0;
                    c_col_d  = '0;
                    lag_d    = '0;
                end
            end
            default: begin
                if (accept) begin
                    if (in_col_q == width_q - ONE) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + ONE;
                    end else begin
                        in_col_d = in_col_q + ONE;
                    end
                    if (lag_q != ({1'b0, width_q} + (W_SIZE+1)'(1))) begin
                        lag_d = lag_q + (W_SIZE+1)'(1);
                    end
                    if (state_q == ST_RUN && last_in && is3_q) begin
                        state_d = ST_FLUSH;
                    end
                end
                if (emit) begin
                    vld_d = 1'b1;
                    row_d = c_row_q;
                    col_d = c_col_q;
                    if (is3_q) begin
                        din_d = pad_window(win_d, c_row_q == '0, c_row_q == height_q - ONE,
                                           c_col_q == '0, c_col_q == width_q - ONE);
                    end else begin
                        din_d          = '0;
                        din_d[WI-1:0]  = samp;
                    end
                    if (c_col_q == width_q - ONE) begin
                        c_col_d = '0;
                        c_row_d = c_row_q + ONE;
                    end else begin
                        c_col_d = c_col_q + ONE;
                    end
                    // Last window closes the frame; busy drops with it.
                    if (end_c) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            is3_q    <= 1'b0;
            in_row_q <= '0;
            in_col_q <= '0;
            c_row_q  <= '0;
            c_col_q  <= '0;
            lag_q    <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            width_q  <= width_d;
            height_q <= height_d;
            is3_q    <= is3_d;
            in_row_q <= in_row_d;
            in_col_q <= in_col_d;
            c_row_q  <= c_row_d;
            c_col_q  <= c_col_d;
            lag_q    <= lag_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            row_q    <= row_d;
            col_q    <= col_d;
            din_q    <= din_d;
        end
    end

    // Window contents need no reset: stale entries are masked or shifted out
    // before the first window of a frame is emitted.
    always_ff @(posedge HCLK) begin
        win_q <= win_d;
    end

    assign o_busy            = busy_q;
    assign s_if.o_din        = din_q;
    assign s_if.o_vld        = vld_q;
    assign s_if.o_row        = row_q;
    assign s_if.o_col        = col_q;
    assign s_if.o_frame_done = done_q;

endmodule

// File: tb/tb_cnn_win_gen.sv
module tb_cnn_win_gen;
    import cnn_pkg::*;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              i_start = 1'b0;
    logic [W_SIZE-1:0] i_width = '0;
    logic [W_SIZE-1:0] i_height = '0;
    logic              i_is_conv3x3 = 1'b0;
    logic              o_busy;

    cnn_win_gen_if ifc ();

    cnn_win_gen dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .i_start      (i_start),
        .i_width      (i_width),
        .i_height     (i_height),
        .i_is_conv3x3 (i_is_conv3x3),
        .o_busy       (o_busy),
        .s_if         (ifc)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [N*WI-1:0] din;
        int              row;
        int              col;
    } exp_t;

    exp_t            exp_q[$];
    int              nvec = 0;
    int              nerr = 0;
    int              img[16384];
    int              cur_w = 1;
    logic [N*WI-1:0] got_din[64];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    function automatic logic [127:0] pack9(input int v[9]);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*WI +: WI] = WI'(v[k]);
        return r;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_vld"},  ifc.o_vld, 0);
        chk({tag, "_din"},  ifc.o_din, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_row"},  ifc.o_row, 0);
        chk({tag, "_col"},  ifc.o_col, 0);
        chk({tag, "_done"}, ifc.o_frame_done, 0);
    endtask

    // Scoreboard: every o_vld must match the next window of the reference.
    always @(negedge HCLK) begin
        if (HRESETn && ifc.o_vld) begin
            if (exp_q.size() == 0) begin
                chk("extra_vld", ifc.o_vld, 0);
            end else begin
                exp_t e;
                bit   last;
                int   idx;
                e    = exp_q.pop_front();
                last = (exp_q.size() == 0);
                chk("din",  ifc.o_din, e.din);
                chk("row",  ifc.o_row, e.row);
                chk("col",  ifc.o_col, e.col);
                chk("done", ifc.o_frame_done, last);
                chk("busy", o_busy, !last);
                idx = int'(ifc.o_row) * cur_w + int'(ifc.o_col);
                if (idx < 64) got_din[idx] = ifc.o_din;
            end
        end else if (HRESETn && ifc.o_frame_done) begin
            chk("done_no_vld", ifc.o_frame_done, 0);
        end
    end

    // base < 0: random pixels, else base+i. vmode 0: back-to-back, 1: toggle, 2: random.
    task automatic run_frame(input int w, input int h, input bit is3, input int vmode,
                             input int base, input int abort_at, input bit glitch);
        int  total, sent, cyc, bound;
        bit  v, prev_v, gdone, aborted;
        total = w * h;
        cur_w = w;
        for (int k = 0; k < 64; k++) got_din[k] = '0;
        for (int i = 0; i < total; i++)
            img[i] = (base < 0) ? int'($urandom_range(0, 255)) : ((base + i) & 255);
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                exp_t e;
                e.din = '0;
                e.row = r;
                e.col = c;
                if (is3) begin
                    for (int dy = 0; dy < 3; dy++) begin
                        for (int dx = 0; dx < 3; dx++) begin
                            int rr, cc;
                            rr = r - 1 + dy;
                            cc = c - 1 + dx;
                            if (rr >= 0 && rr < h && cc >= 0 && cc < w)
                                e.din[(3*dy+dx)*WI +: WI] = WI'(img[rr*w+cc]);
                        end
                    end
                end else begin
                    e.din[WI-1:0] = WI'(img[r*w+c]);
                end
                exp_q.push_back(e);
            end
        end

        @(negedge HCLK);
        i_width      = W_SIZE'(w);
        i_height     = W_SIZE'(h);
        i_is_conv3x3 = is3;
        i_start      = 1'b1;
        sent = 0; cyc = 0; prev_v = 0; gdone = 0; aborted = 0;
        while (sent < total) begin
            @(negedge HCLK);
            i_start = 1'b0;
            if (!is3) chk("lat1x1", ifc.o_vld, prev_v);
            if (abort_at >= 0 && sent == abort_at) begin
                aborted = 1;
                break;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 99) < 70);
            endcase
            if (glitch && !gdone && sent == total / 2) begin
                i_start = 1'b1;
                i_width = W_SIZE'(5);
                gdone   = 1;
            end
            ifc.i_pix_vld = v;
            ifc.i_pix     = v ? WI'(img[sent]) : WI'($urandom_range(0, 255));
            prev_v = v;
            if (v) sent++;
            cyc++;
        end

        if (aborted) begin
            HRESETn = 1'b0;
            #1;
            chk_outputs_zero("rst_mid");
            ifc.i_pix_vld = 1'b0;
            repeat (2) @(negedge HCLK);
            exp_q.delete();
            HRESETn = 1'b1;
            return;
        end

        @(negedge HCLK);
        ifc.i_pix_vld = 1'b0;
        i_start       = 1'b0;
        if (!is3) chk("lat1x1", ifc.o_vld, prev_v);
        bound = 3 * total + w + 50;
        for (int k = 0; k < bound; k++) begin
            if (exp_q.size() == 0 && !o_busy) break;
            @(negedge HCLK);
            #1;
        end
        chk("frame_left", exp_q.size(), 0);
        chk("busy_end", o_busy, 0);
        repeat (3) @(negedge HCLK);
    endtask

    task automatic bad_start(input int w, input int h);
        @(negedge HCLK);
        i_width       = W_SIZE'(w);
        i_height      = W_SIZE'(h);
        i_is_conv3x3  = 1'b1;
        i_start       = 1'b1;
        ifc.i_pix_vld = 1'b1;
        ifc.i_pix     = 8'h5a;
        repeat (4) begin
            @(negedge HCLK);
            i_start = 1'b0;
            chk("badstart_busy", o_busy, 0);
            chk("badstart_vld", ifc.o_vld, 0);
        end
        ifc.i_pix_vld = 1'b0;
    endtask

    initial begin
        int v00[9], v11[9], v33[9], v1x1[9], vw1[9];
        v00  = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        v11  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        v33  = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
        v1x1 = '{14, 0, 0, 0, 0, 0, 0, 0, 0};
        vw1  = '{0, 7, 0, 0, 8, 0, 0, 9, 0};
        ifc.i_pix     = '0;
        ifc.i_pix_vld = 1'b0;

        repeat (3) @(negedge HCLK);
        chk_outputs_zero("reset");
        HRESETn = 1'b1;
        @(negedge HCLK);

        // 3x3, 4x4, pixels 1..16
        run_frame(4, 4, 1'b1, 0, 1, -1, 1'b0);
        chk("t1_c00", got_din[0], pack9(v00));
        chk("t1_c11", got_din[5], pack9(v11));
        chk("t1_c33", got_din[15], pack9(v33));

        // 1x1, 3x3, pixels 10..18
        run_frame(3, 3, 1'b0, 0, 10, -1, 1'b0);
        chk("t2_c11", got_din[4], pack9(v1x1));

        // 3x3, 128x128, toggling valid
        run_frame(128, 128, 1'b1, 1, -1, -1, 1'b0);

        // i_start during RUN, then illegal sizes at IDLE
        run_frame(6, 5, 1'b1, 2, -1, -1, 1'b1);
        bad_start(0, 4);
        bad_start(4, 0);

        // reset after 5 rows of an 8x8 frame, then a clean restart
        run_frame(8, 8, 1'b1, 0, -1, 40, 1'b0);
        chk_outputs_zero("post_rst");
        run_frame(8, 8, 1'b1, 0, -1, -1, 1'b0);

        // single column
        run_frame(1, 3, 1'b1, 0, 7, -1, 1'b0);
        chk("t6_c10", got_din[1], pack9(vw1));
        run_frame(5, 1, 1'b1, 2, -1, -1, 1'b0);

        // randomized frames
        for (int t = 0; t < 8; t++) begin
            run_frame(int'($urandom_range(1, 10)), int'($urandom_range(1, 6)),
                      1'($urandom_range(0, 1)), 2, -1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
